// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg: state encoding and shared widths for the layer load sequencer
package cnn_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD_W, LOAD_I, SETTLE, ROUTE, DONE} state_t;
  localparam int TIMER_W = 16;
  localparam int OFMAP_W = 16;
endpackage

// File: rtl/seq_counter.sv
// seq_counter: loadable up-counter with terminal-count flag
module seq_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic         o_tc
);
  logic [W-1:0] r_count;
  always_ff @(posedge i_clk)
    if (i_rst) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_en) r_count <= r_count + 1'b1;
  assign o_count = r_count;
  assign o_tc = r_count == i_term;
endmodule

// File: rtl/layer_load_sequencer.sv
// layer_load_sequencer: loads kernel then ifmap words into the scratchpads,
// runs the route phase under a watchdog and reports completion or error.
module layer_load_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int SRAM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 8,
  parameter int SETTLE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]      i_cmd_w_words,
  input  logic [ADDR_WIDTH-1:0]      i_cmd_i_words,
  input  logic [SRAM_DATA_WIDTH-1:0] i_s_data,
  input  logic                       i_s_valid,
  output logic                       o_s_ready,
  output logic                       o_write_en,
  output logic                       o_spad_select,
  output logic [ADDR_WIDTH-1:0]      o_write_addr,
  output logic [SRAM_DATA_WIDTH-1:0] o_data_in,
  output logic [ADDR_WIDTH-1:0]      o_i_addr_end,
  output logic                       o_reg_clear,
  output logic                       o_route_en,
  input  logic                       i_ofmap_valid,
  input  logic                       i_done,
  output logic                       o_busy,
  output logic                       o_layer_done,
  output logic                       o_error,
  output logic [OFMAP_W-1:0]         o_ofmap_count
);
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_w_words, r_i_words;
  logic [ADDR_WIDTH-1:0] w_beat_cnt, w_beat_term;
  logic [TIMER_W-1:0]    w_timer_cnt, w_timer_term;
  logic w_load, w_beat, w_beat_tc, w_timer_en, w_timer_tc, w_unused;
  assign w_load      = r_state == LOAD_W || r_state == LOAD_I;
  assign w_beat      = i_s_valid && w_load;
  assign o_s_ready   = w_load;
  assign o_cmd_ready = r_state == IDLE;
  assign o_busy      = r_state != IDLE;
  assign w_beat_term = r_state == LOAD_W ? r_w_words - 1'b1 : r_i_words - 1'b1;
  assign w_timer_en  = r_state == SETTLE || r_state == ROUTE;
  assign w_timer_term = r_state == SETTLE ? TIMER_W'(SETTLE_CYCLES - 1) : TIMER_W'(TIMEOUT_CYCLES - 1);
  assign w_unused    = ^w_timer_cnt;
  // Beat index doubles as write address; it restarts at 0 for each scratchpad.
  seq_counter #(.W(ADDR_WIDTH)) u_beat (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(!w_load || (w_beat && w_beat_tc)),
    .i_load_val('0), .i_en(w_beat), .i_term(w_beat_term),
    .o_count(w_beat_cnt), .o_tc(w_beat_tc)
  );
  // Shared timer: settle delay, then reloaded to 0 as the route watchdog.
  seq_counter #(.W(TIMER_W)) u_timer (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(!w_timer_en || (r_state == SETTLE && w_timer_tc)),
    .i_load_val('0), .i_en(w_timer_en), .i_term(w_timer_term),
    .o_count(w_timer_cnt), .o_tc(w_timer_tc)
  );
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_state       <= IDLE;
      r_w_words     <= '0;
      r_i_words     <= '0;
      o_write_en    <= 1'b0;
      o_spad_select <= 1'b0;
      o_write_addr  <= '0;
      o_data_in     <= '0;
      o_i_addr_end  <= '0;
      o_reg_clear   <= 1'b0;
      o_route_en    <= 1'b0;
      o_layer_done  <= 1'b0;
      o_error       <= 1'b0;
      o_ofmap_count <= '0;
    end else begin
      o_write_en   <= w_beat;
      o_reg_clear  <= 1'b0;
      o_layer_done <= 1'b0;
      o_error      <= 1'b0;
      if (w_beat) begin
        o_spad_select <= r_state == LOAD_I;
        o_write_addr  <= w_beat_cnt;
        o_data_in     <= i_s_data;
      end
      case (r_state)
        IDLE: if (i_cmd_valid) begin
          if (i_cmd_w_words == '0 || i_cmd_i_words == '0) o_error <= 1'b1;
          else begin
            r_state      <= CLEAR;
            o_reg_clear  <= 1'b1;
            r_w_words    <= i_cmd_w_words;
            r_i_words    <= i_cmd_i_words;
            o_i_addr_end <= i_cmd_i_words - 1'b1;
          end
        end
        CLEAR: begin
          r_state       <= LOAD_W;
          o_ofmap_count <= '0;
        end
        LOAD_W: if (w_beat && w_beat_tc) r_state <= LOAD_I;
        LOAD_I: if (w_beat && w_beat_tc) r_state <= SETTLE;
        SETTLE: if (w_timer_tc) begin
          r_state    <= ROUTE;
          o_route_en <= 1'b1;
        end
        ROUTE: begin
          if (i_ofmap_valid && o_ofmap_count != '1) o_ofmap_count <= o_ofmap_count + 1'b1;
          if (i_done) begin
            r_state      <= DONE;
            o_route_en   <= 1'b0;
            o_layer_done <= 1'b1;
          end else if (w_timer_tc) begin
            r_state    <= IDLE;
            o_route_en <= 1'b0;
            o_error    <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_layer_load_sequencer.sv
// tb_layer_load_sequencer: directed checks of load ordering, settle timing,
// route completion, bad commands, watchdog timeout and mid-load reset.
module tb_layer_load_sequencer;
  logic        clk = 0, rst = 1;
  logic        i_cmd_valid = 0, i_s_valid = 0, i_ofmap_valid = 0, i_done = 0;
  logic [7:0]  i_cmd_w_words = 0, i_cmd_i_words = 0;
  logic [63:0] i_s_data = 0;
  logic        o_cmd_ready, o_s_ready, o_write_en, o_spad_select, o_reg_clear, o_route_en;
  logic        o_busy, o_layer_done, o_error;
  logic [7:0]  o_write_addr, o_i_addr_end;
  logic [63:0] o_data_in;
  logic [15:0] o_ofmap_count;
  int n_chk = 0, n_pass = 0, cyc = 0, last_wr = 0, route_rise = 0;
  int done_cnt = 0, err_cnt = 0, clr_cnt = 0;
  logic [72:0] wq[$];

  layer_load_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_w_words(i_cmd_w_words), .i_cmd_i_words(i_cmd_i_words),
    .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
    .o_write_en(o_write_en), .o_spad_select(o_spad_select), .o_write_addr(o_write_addr),
    .o_data_in(o_data_in), .o_i_addr_end(o_i_addr_end), .o_reg_clear(o_reg_clear),
    .o_route_en(o_route_en), .i_ofmap_valid(i_ofmap_valid), .i_done(i_done),
    .o_busy(o_busy), .o_layer_done(o_layer_done), .o_error(o_error),
    .o_ofmap_count(o_ofmap_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (o_write_en) begin
      wq.push_back({o_spad_select, o_write_addr, o_data_in});
      last_wr = cyc;
    end
    if (o_layer_done) done_cnt++;
    if (o_error) err_cnt++;
    if (o_reg_clear) clr_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] pat(input int k);
    return {32'hC0DE0000 | 32'(k), ~32'(k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int w, input int i);
    i_cmd_valid = 1;
    i_cmd_w_words = 8'(w);
    i_cmd_i_words = 8'(i);
    tick();
    i_cmd_valid = 0;
  endtask

  task automatic stream(input int first, input int n, input bit stall);
    int sent = 0;
    int guard = 0;
    bit ph = 0;
    while (sent < n && guard < 4 * n + 20) begin
      i_s_valid = !(stall && ph);
      ph = !ph;
      i_s_data = pat(first + sent);
      @(negedge clk);
      if (i_s_valid && o_s_ready) sent++;
      tick();
      guard++;
    end
    i_s_valid = 0;
    check("stream_beats", sent, n);
  endtask

  task automatic wait_route();
    int g = 0;
    while (!o_route_en && g < 50) begin
      tick();
      g++;
    end
    route_rise = cyc;
    check("route_en_rise", o_route_en, 1);
  endtask

  task automatic verify_writes(input int w, input int i);
    check("wr_count", wq.size(), w + i);
    foreach (wq[k])
      check("wr_entry", wq[k], {(k >= w) ? 1'b1 : 1'b0, 8'(k >= w ? k - w : k), pat(k)});
  endtask

  initial begin
    int e0, n0, d0, g;
    repeat (3) tick();
    check("rst_busy", o_busy, 0);
    check("rst_write_en", o_write_en, 0);
    check("rst_route_en", o_route_en, 0);
    check("rst_ofmap_count", o_ofmap_count, 0);
    rst = 0;
    tick();
    check("idle_cmd_ready", o_cmd_ready, 1);
    check("idle_error", o_error, 0);
    // Layer 1: no stalls, route finished by a bare i_done.
    send_cmd(9, 12);
    check("clear_pulse", o_reg_clear, 1);
    stream(0, 21, 0);
    wait_route();
    verify_writes(9, 12);
    check("i_addr_end", o_i_addr_end, 11);
    check("settle_gap", route_rise - last_wr, 2);
    check("clear_count", clr_cnt, 1);
    i_done = 1;
    tick();
    i_done = 0;
    check("l1_layer_done", o_layer_done, 1);
    check("l1_route_low", o_route_en, 0);
    tick();
    check("l1_cmd_ready", o_cmd_ready, 1);
    check("l1_done_count", done_cnt, 1);
    // Layer 2: stalled stream, then 64 ofmap beats with i_done on the last.
    wq.delete();
    send_cmd(9, 12);
    stream(0, 21, 1);
    wait_route();
    verify_writes(9, 12);
    check("l2_settle_gap", route_rise - last_wr, 2);
    for (int p = 0; p < 64; p++) begin
      i_ofmap_valid = 1;
      i_done = (p == 63);
      tick();
    end
    i_ofmap_valid = 0;
    i_done = 0;
    check("ofmap_count", o_ofmap_count, 64);
    check("l2_layer_done", o_layer_done, 1);
    check("l2_route_low", o_route_en, 0);
    check("l2_cmd_ready_in_done", o_cmd_ready, 0);
    tick();
    check("l2_pulse_width", o_layer_done, 0);
    check("l2_cmd_ready", o_cmd_ready, 1);
    check("l2_ofmap_hold", o_ofmap_count, 64);
    // Reset in the middle of LOAD_I, then a fresh layer.
    wq.delete();
    send_cmd(3, 6);
    stream(0, 5, 0);
    check("midload_busy", o_busy, 1);
    rst = 1;
    tick();
    check("rrst_write_en", o_write_en, 0);
    check("rrst_busy", o_busy, 0);
    check("rrst_s_ready", o_s_ready, 0);
    check("rrst_addr", o_write_addr, 0);
    check("rrst_data", o_data_in, 0);
    check("rrst_addr_end", o_i_addr_end, 0);
    rst = 0;
    tick();
    wq.delete();
    send_cmd(4, 5);
    stream(0, 9, 0);
    wait_route();
    verify_writes(4, 5);
    i_done = 1;
    tick();
    i_done = 0;
    tick();
    // Bad commands: zero kernel or zero ifmap words.
    e0 = err_cnt;
    n0 = wq.size();
    send_cmd(0, 7);
    check("bad_w_error", o_error, 1);
    check("bad_w_idle", o_busy, 0);
    tick();
    check("bad_w_pulse", o_error, 0);
    send_cmd(5, 0);
    check("bad_i_error", o_error, 1);
    tick();
    tick();
    check("bad_err_count", err_cnt - e0, 2);
    check("bad_no_write", wq.size(), n0);
    check("bad_cmd_ready", o_cmd_ready, 1);
    // Watchdog timeout with no i_done.
    d0 = done_cnt;
    send_cmd(2, 3);
    stream(0, 5, 0);
    wait_route();
    g = 0;
    while (!o_error && g < 200) begin
      tick();
      g++;
    end
    check("timeout_cycles", cyc - route_rise, 100);
    check("timeout_error", o_error, 1);
    check("timeout_route_low", o_route_en, 0);
    check("timeout_no_done", done_cnt - d0, 0);
    check("timeout_idle", o_cmd_ready, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
